feed_rx_blocker: RTL

- Consumer (responder) end of the autotest feed interface: feed_data / data_ready / stop_feed / busy.
- Accepts FEED_DATA_SIZE-bit words streamed by the autotest feeder and packs them into BLOCK_WIDTH-bit blocks.
- Applies bit-pad-one padding at end of message.
- Hands blocks to a downstream permutation/hash core over a valid/ready handshake, and reports the message length in bits.
- Sits between the feeder and any UUT core that needs whole blocks rather than raw words.

---
 rtl/feed_rx_blocker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/feed_rx_blocker.sv
// Feed-interface responder: packs fed words into blocks, applies bit-pad-one, hands blocks downstream.
// Define FEED_RX_LSB_FIRST_EN for LSB-first packing (word 0 in the low bits, pad word 0x...0001).
//
// state     | meaning
// COLLECT   | accepting words into the assembly register
// EMIT      | full (non-final) block offered downstream
// PAD       | writing the pad word into slot idx
// EMIT_LAST | final padded block offered downstream
// DONE      | message finished, waiting for reset

module feed_rx_blocker #(
   parameter int FEED_DATA_SIZE = 16,
   parameter int BLOCK_WIDTH    = 64,
   parameter int LEN_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FEED_DATA_SIZE-1:0] feed_data,
   input  logic                      data_ready,
   input  logic                      stop_feed,
   output logic                      busy,
   output logic [BLOCK_WIDTH-1:0]    blk_data,
   output logic                      blk_valid,
   input  logic                      blk_ready,
   output logic                      blk_last,
   output logic [LEN_WIDTH-1:0]      msg_len,
   output logic                      done,
   output logic                      proto_err,
   output logic                      len_ovf
);

   localparam int W     = BLOCK_WIDTH / FEED_DATA_SIZE;
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

`ifdef FEED_RX_LSB_FIRST_EN
   localparam logic [FEED_DATA_SIZE-1:0] PAD_WORD = FEED_DATA_SIZE'(1);
`else
   localparam logic [FEED_DATA_SIZE-1:0] PAD_WORD = {1'b1, {(FEED_DATA_SIZE-1){1'b0}}};
`endif

   typedef enum logic [2:0] {COLLECT, EMIT, PAD, EMIT_LAST, DONE} state_t;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic [BLOCK_WIDTH-1:0]   asm_blk;
   logic [BLOCK_WIDTH-1:0]   asm_next;
   logic [BLOCK_WIDTH-1:0]   pad_blk;
   logic [LEN_WIDTH:0]       len_sum;

   function automatic int slot_lo(input int k);
`ifdef FEED_RX_LSB_FIRST_EN
      return k * FEED_DATA_SIZE;
`else
      return BLOCK_WIDTH - (k + 1) * FEED_DATA_SIZE;
`endif
   endfunction

   // Slots beyond idx are forced to zero when padding, independent of the assembly history.
   always_comb begin
      asm_next = asm_blk;
      pad_blk  = asm_blk;
      for (int k = 0; k < W; k++) begin
         if (IDX_W'(k) == idx) begin
            asm_next[slot_lo(k) +: FEED_DATA_SIZE] = feed_data;
            pad_blk[slot_lo(k) +: FEED_DATA_SIZE]  = PAD_WORD;
         end else if (IDX_W'(k) > idx) begin
            pad_blk[slot_lo(k) +: FEED_DATA_SIZE]  = '0;
         end
      end
   end

   assign len_sum = {1'b0, msg_len} + (LEN_WIDTH+1)'(FEED_DATA_SIZE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= COLLECT;
         idx       <= '0;
         asm_blk   <= '0;
         blk_data  <= '0;
         msg_len   <= '0;
         busy      <= 1'b0;
         blk_valid <= 1'b0;
         blk_last  <= 1'b0;
         done      <= 1'b0;
         proto_err <= 1'b0;
         len_ovf   <= 1'b0;
      end else begin
         if (data_ready && state != COLLECT)
            proto_err <= 1'b1;
         case (state)
            COLLECT: begin
               if (data_ready) begin
                  asm_blk <= asm_next;
                  idx     <= idx + 1'b1;
                  if (len_sum[LEN_WIDTH]) begin
                     msg_len <= '1;
                     len_ovf <= 1'b1;
                  end else begin
                     msg_len <= len_sum[LEN_WIDTH-1:0];
                  end
                  if (idx == IDX_W'(W-1)) begin
                     state     <= EMIT;
                     blk_data  <= asm_next;
                     busy      <= 1'b1;
                     blk_valid <= 1'b1;
                  end
               end else if (stop_feed) begin
                  state <= PAD;
                  busy  <= 1'b1;
               end
            end
            EMIT: begin
               if (blk_ready) begin
                  asm_blk   <= '0;
                  idx       <= '0;
                  state     <= COLLECT;
                  busy      <= 1'b0;
                  blk_valid <= 1'b0;
               end
            end
            PAD: begin
               blk_data  <= pad_blk;
               state     <= EMIT_LAST;
               blk_valid <= 1'b1;
               blk_last  <= 1'b1;
            end
            EMIT_LAST: begin
               if (blk_ready) begin
                  state     <= DONE;
                  blk_valid <= 1'b0;
                  blk_last  <= 1'b0;
                  done      <= 1'b1;
               end
            end
            DONE: ;
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
